// File: rtl/lfsr_engine_pkg.sv
// lfsr_engine_pkg: shared mode encoding and reference feedback masks for lfsr_engine.
package lfsr_engine_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LFSR = 2'b11
  } lfsr_mode_e;

  // Maximal-length Galois feedback masks for common widths
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;

  // A step is counted in every mode except hold
  function automatic logic mode_counts(input lfsr_mode_e m);
    return (m != MODE_HOLD);
  endfunction

endpackage

// File: rtl/lfsr_engine_next.sv
// lfsr_engine_next: combinational next-state, wrap and lock-up decode.
// With LFSR_ENGINE_MISR_EN defined, mode 11 folds misr_i into each step
// (signature register) and the all-zero lock-up correction is disabled.
module lfsr_engine_next
  import lfsr_engine_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0] SEED_RST = 16'h0001
) (
  input  logic [WIDTH-1:0] state_i,
  input  lfsr_mode_e       mode_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic             lockup_o,
  output logic             count_o
`ifdef LFSR_ENGINE_MISR_EN
  ,input  logic [WIDTH-1:0] misr_i
`endif
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] galois_s;
  logic [WIDTH-1:0] lfsr_nxt_s;

  // Decode the successor of state_i for the selected mode
  always_comb begin
    galois_s   = state_i[0] ? ((state_i >> 1) ^ TAPS) : (state_i >> 1);
`ifdef LFSR_ENGINE_MISR_EN
    lfsr_nxt_s = galois_s ^ misr_i;
`else
    lfsr_nxt_s = galois_s;
`endif
    next_o     = state_i;
    wrap_o     = 1'b0;
    lockup_o   = 1'b0;
    count_o    = mode_counts(mode_i);
    case (mode_i)
      MODE_HOLD: begin
        next_o = state_i;
      end
      MODE_UP: begin
        next_o = state_i + ONE;
        wrap_o = (state_i == ONES);
      end
      MODE_DOWN: begin
        next_o = state_i - ONE;
        wrap_o = (state_i == ZERO);
      end
      MODE_LFSR: begin
`ifdef LFSR_ENGINE_MISR_EN
        next_o = lfsr_nxt_s;
        wrap_o = (lfsr_nxt_s == seed_i);
`else
        if (state_i == ZERO) begin
          // All-zero is a fixed point of the LFSR: recover, skip the wrap check
          next_o   = SEED_RST;
          lockup_o = 1'b1;
        end else begin
          next_o = lfsr_nxt_s;
          wrap_o = (lfsr_nxt_s == seed_i);
        end
`endif
      end
      default: begin
        next_o  = state_i;
        count_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lfsr_engine.sv
// lfsr_engine: WIDTH-bit Galois LFSR / up / down counter with seed-load
// handshake, wrap and lock-up pulses and a step counter.
// Optional feature macro: LFSR_ENGINE_MISR_EN (adds misr_in, signature mode).
module lfsr_engine
  import lfsr_engine_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0] SEED_RST = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] state_q,
  output logic             bit_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             lockup
`ifdef LFSR_ENGINE_MISR_EN
  ,input  logic [WIDTH-1:0] misr_in
`endif
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  lfsr_mode_e       mode_s;
  logic [WIDTH-1:0] next_s;
  logic             nxt_wrap_s;
  logic             nxt_lockup_s;
  logic             nxt_count_s;
  logic             load_fix_s;

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] seed_d, seed_q;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;
  logic             lockup_d, lockup_q;

  assign mode_s     = lfsr_mode_e'(mode);
  assign load_ready = ena;
  assign bit_out    = state_q[0];
  assign step_cnt   = cnt_q;
  assign wrap       = wrap_q;
  assign lockup     = lockup_q;

`ifdef LFSR_ENGINE_MISR_EN
  // An all-zero signature seed is legal, so no correction on load
  assign load_fix_s = 1'b0;
`else
  assign load_fix_s = (mode_s == MODE_LFSR) && (load_data == ZERO);
`endif

  lfsr_engine_next #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .SEED_RST (SEED_RST)
  ) u_next (
    .state_i  (state_q),
    .mode_i   (mode_s),
    .seed_i   (seed_q),
    .next_o   (next_s),
    .wrap_o   (nxt_wrap_s),
    .lockup_o (nxt_lockup_s),
    .count_o  (nxt_count_s)
`ifdef LFSR_ENGINE_MISR_EN
    ,.misr_i  (misr_in)
`endif
  );

  // Priority select: disabled > load > step > hold; pulses default low
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (!ena) begin
      state_d = state_q;
    end else if (load_valid) begin
      cnt_d = ZERO;
      if (load_fix_s) begin
        state_d  = SEED_RST;
        seed_d   = SEED_RST;
        lockup_d = 1'b1;
      end else begin
        state_d = load_data;
        seed_d  = load_data;
      end
    end else if (step) begin
      state_d  = next_s;
      wrap_d   = nxt_wrap_s;
      lockup_d = nxt_lockup_s;
      if (nxt_wrap_s) begin
        cnt_d = ZERO;
      end else if (nxt_count_s) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, seed, step counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED_RST;
      seed_q   <= SEED_RST;
      cnt_q    <= ZERO;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

endmodule

// File: tb/tb_lfsr_engine.sv
// tb_lfsr_engine: scoreboard bench for lfsr_engine (16-bit and 4-bit instances).
module tb_lfsr_engine;

  typedef struct {
    int          dut;
    logic [31:0] st;
    logic [31:0] cnt;
    logic        wr;
    logic        lk;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena16 = 1'b1, step16 = 1'b0, lv16 = 1'b0;
  logic [1:0]  mode16 = 2'b00;
  logic [15:0] ld16 = 16'h0000, misr16 = 16'h0000;
  logic        ena4 = 1'b1, step4 = 1'b0, lv4 = 1'b0;
  logic [1:0]  mode4 = 2'b00;
  logic [3:0]  ld4 = 4'h0, misr4 = 4'h0;

  logic        load_ready16, bit_out16, wrap16, lockup16;
  logic [15:0] state16, cnt16;
  logic        load_ready4, bit_out4, wrap4, lockup4;
  logic [3:0]  state4, cnt4;

  always #5 clk = ~clk;

  lfsr_engine #(.WIDTH(16), .TAPS(16'hB400), .SEED_RST(16'h0001)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena16), .mode(mode16), .step(step16),
    .load_valid(lv16), .load_data(ld16), .load_ready(load_ready16),
    .state_q(state16), .bit_out(bit_out16), .step_cnt(cnt16),
    .wrap(wrap16), .lockup(lockup16)
`ifdef LFSR_ENGINE_MISR_EN
    ,.misr_in(misr16)
`endif
  );

  lfsr_engine #(.WIDTH(4), .TAPS(4'hC), .SEED_RST(4'h1)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .mode(mode4), .step(step4),
    .load_valid(lv4), .load_data(ld4), .load_ready(load_ready4),
    .state_q(state4), .bit_out(bit_out4), .step_cnt(cnt4),
    .wrap(wrap4), .lockup(lockup4)
`ifdef LFSR_ENGINE_MISR_EN
    ,.misr_in(misr4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus to one instance and queue the response due after the edge
  task automatic cyc(input int d, input logic [1:0] md, input logic stp, input logic lv,
                     input logic [15:0] ld, input logic [15:0] est, input logic [15:0] ecnt,
                     input logic ewr, input logic elk, input string nm);
    exp_t e;
    step16 = 1'b0; lv16 = 1'b0; step4 = 1'b0; lv4 = 1'b0;
    if (d == 0) begin
      mode16 = md; step16 = stp; lv16 = lv; ld16 = ld;
    end else begin
      mode4 = md; step4 = stp; lv4 = lv; ld4 = ld[3:0];
    end
    e.dut = d; e.st = {16'h0000, est}; e.cnt = {16'h0000, ecnt};
    e.wr = ewr; e.lk = elk; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge with a pending expectation, compare the registered outputs
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.dut == 0) begin
        chk({mon_e.nm, ".state"},  {16'h0000, state16}, mon_e.st);
        chk({mon_e.nm, ".cnt"},    {16'h0000, cnt16},   mon_e.cnt);
        chk({mon_e.nm, ".wrap"},   {31'h0, wrap16},     {31'h0, mon_e.wr});
        chk({mon_e.nm, ".lockup"}, {31'h0, lockup16},   {31'h0, mon_e.lk});
      end else begin
        chk({mon_e.nm, ".state"},  {28'h0, state4},  mon_e.st);
        chk({mon_e.nm, ".cnt"},    {28'h0, cnt4},    mon_e.cnt);
        chk({mon_e.nm, ".wrap"},   {31'h0, wrap4},   {31'h0, mon_e.wr});
        chk({mon_e.nm, ".lockup"}, {31'h0, lockup4}, {31'h0, mon_e.lk});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  logic [15:0] seq4 [15];

  initial begin
    seq4 = '{16'hC, 16'h6, 16'h3, 16'hD, 16'hA, 16'h5, 16'hE, 16'h7,
             16'hF, 16'hB, 16'h9, 16'h8, 16'h4, 16'h2, 16'h1};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Reset values
    chk("rst.state", {16'h0, state16}, 32'h1);
    chk("rst.cnt", {16'h0, cnt16}, 32'h0);
    chk("rst.wrap", {31'h0, wrap16}, 32'h0);
    chk("rst.lockup", {31'h0, lockup16}, 32'h0);
    chk("rst.load_ready", {31'h0, load_ready16}, 32'h1);
    chk("rst.bit_out", {31'h0, bit_out16}, 32'h1);

    // Three Galois steps from the reset seed
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'hB400, 16'd1, 1'b0, 1'b0, "lfsr1");
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h5A00, 16'd2, 1'b0, 1'b0, "lfsr2");
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h2D00, 16'd3, 1'b0, 1'b0, "lfsr3");
    chk("bit_out_2d00", {31'h0, bit_out16}, 32'h0);

    // Up-count wrap, pulse lasts one cycle while step stays high
    cyc(0, 2'b01, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'd0, 1'b0, 1'b0, "up_load");
    cyc(0, 2'b01, 1'b1, 1'b0, 16'h0, 16'hFFFF, 16'd1, 1'b0, 1'b0, "up1");
    cyc(0, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0000, 16'd0, 1'b1, 1'b0, "up_wrap");
    cyc(0, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0001, 16'd1, 1'b0, 1'b0, "up_after");
    cyc(0, 2'b01, 1'b0, 1'b0, 16'h0, 16'h0001, 16'd1, 1'b0, 1'b0, "up_idle");

    // Down-count wrap, then hold mode does not move or count
    cyc(0, 2'b10, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, "dn_load");
    cyc(0, 2'b10, 1'b1, 1'b0, 16'h0, 16'hFFFF, 16'd0, 1'b1, 1'b0, "dn_wrap");
    cyc(0, 2'b00, 1'b1, 1'b0, 16'h0, 16'hFFFF, 16'd0, 1'b0, 1'b0, "hold_step");

    // Zero load in LFSR mode
`ifdef LFSR_ENGINE_MISR_EN
    cyc(0, 2'b11, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, "load0");
`else
    cyc(0, 2'b11, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'd0, 1'b0, 1'b1, "load0");
`endif
    cyc(0, 2'b11, 1'b0, 1'b0, 16'h0, state16, 16'd0, 1'b0, 1'b0, "load0_idle");

    // Load and step together: load wins; then mode change keeps seed and count
    cyc(0, 2'b11, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'd0, 1'b0, 1'b0, "load_step");
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h091A, 16'd1, 1'b0, 1'b0, "lfsr_even");
    cyc(0, 2'b01, 1'b1, 1'b0, 16'h0, 16'h091B, 16'd2, 1'b0, 1'b0, "mode_up");
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'hB08D, 16'd3, 1'b0, 1'b0, "mode_lfsr");

    // All-zero state stepped in LFSR mode
    cyc(0, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, "zero_load");
`ifdef LFSR_ENGINE_MISR_EN
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0000, 16'd0, 1'b1, 1'b0, "zero_step");
`else
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0001, 16'd1, 1'b0, 1'b1, "zero_step");
`endif

    // Disabled: everything holds, pulses drop, handshake not ready
    ena16 = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef LFSR_ENGINE_MISR_EN
      cyc(0, 2'b11, 1'b1, 1'b1, 16'hAAAA, 16'h0000, 16'd0, 1'b0, 1'b0, "ena_low");
`else
      cyc(0, 2'b11, 1'b1, 1'b1, 16'hAAAA, 16'h0001, 16'd1, 1'b0, 1'b0, "ena_low");
`endif
      chk("ena_low.load_ready", {31'h0, load_ready16}, 32'h0);
    end
    ena16 = 1'b1;

`ifdef LFSR_ENGINE_MISR_EN
    // Signature mode: all-zero result is legal and not corrected
    cyc(0, 2'b11, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'd0, 1'b0, 1'b0, "misr_load");
    misr16 = 16'hB400;
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0000, 16'd1, 1'b0, 1'b0, "misr1");
    misr16 = 16'h0000;
    cyc(0, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0000, 16'd2, 1'b0, 1'b0, "misr2");
`endif

    // 4-bit LFSR full period from seed 1
    cyc(1, 2'b11, 1'b0, 1'b1, 16'h1, 16'h1, 16'd0, 1'b0, 1'b0, "w4_load");
    for (int i = 0; i < 15; i++) begin
      cyc(1, 2'b11, 1'b1, 1'b0, 16'h0, seq4[i], (i == 14) ? 16'd0 : 16'(i + 1),
          (i == 14), 1'b0, $sformatf("w4_step%0d", i + 1));
    end

    // Asynchronous reset mid-cycle
    cyc(0, 2'b01, 1'b0, 1'b1, 16'h5555, 16'h5555, 16'd0, 1'b0, 1'b0, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.state", {16'h0, state16}, 32'h1);
    chk("async_rst.cnt", {16'h0, cnt16}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_drain", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
